// File: rtl/qcl_bram_rd_stream.sv
// Streaming read master for a 1-cycle-latency BRAM: turns (addr, len) commands into a
// ready/valid word stream, using a 2-entry skid buffer and issue credit to absorb read latency.
module qcl_bram_rd_stream #(
    parameter int  width_p       = 32,
    parameter int  els_p         = 16,
    localparam int addr_width_lp = (els_p == 1) ? 1 : $clog2(els_p),
    localparam int len_width_lp  = $clog2(els_p + 1)
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     cmd_v_i,
    input  logic [addr_width_lp-1:0] cmd_addr_i,
    input  logic [len_width_lp-1:0]  cmd_len_i,
    output logic                     cmd_ready_o,
    output logic                     mem_r_v_o,
    output logic [addr_width_lp-1:0] mem_r_addr_o,
    input  logic [width_p-1:0]       mem_r_data_i,
    output logic                     data_v_o,
    output logic [width_p-1:0]       data_o,
    output logic                     data_last_o,
    input  logic                     data_ready_i,
    output logic                     done_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

    state_e                   state_q, state_d;
    logic [addr_width_lp-1:0] addr_q, addr_d;
    logic [addr_width_lp-1:0] last_addr_q, last_addr_d;
    logic [len_width_lp-1:0]  rem_q, rem_d;
    logic [1:0]               occ_q, occ_d;
    logic                     infl_q, infl_d;
    logic                     infl_last_q, infl_last_d;
    logic                     done_q, done_d;
    logic                     last0_q, last0_d;
    logic                     last1_q, last1_d;
    logic [width_p-1:0]       data0_q, data0_d;
    logic [width_p-1:0]       data1_q, data1_d;

    logic pop;
    logic issue;
    logic credit;
    logic cmd_fire;

    assign cmd_ready_o  = (state_q == IDLE);
    assign cmd_fire     = cmd_v_i & cmd_ready_o;
    assign data_v_o     = (occ_q != 2'd0);
    assign data_o       = data0_q;
    assign data_last_o  = data_v_o & last0_q;
    assign done_o       = done_q;
    assign pop          = data_v_o & data_ready_i;
    // occ + infl - pop < 2, rearranged to stay non-negative
    assign credit       = ({1'b0, occ_q} + {2'b00, infl_q}) < (3'd2 + {2'b00, pop});
    assign issue        = (state_q == ISSUE) && (rem_q != '0) && credit;
    assign mem_r_v_o    = issue;
    assign mem_r_addr_o = issue ? addr_q : last_addr_q;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        last_addr_d = last_addr_q;
        rem_d       = rem_q;
        done_d      = 1'b0;
        infl_d      = issue;
        infl_last_d = (rem_q == len_width_lp'(1));
        occ_d       = occ_q;
        last0_d     = last0_q;
        last1_d     = last1_q;
        data0_d     = data0_q;
        data1_d     = data1_q;

        case (state_q)
            IDLE: begin
                if (cmd_fire) begin
                    if (cmd_len_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        addr_d  = cmd_addr_i;
                        rem_d   = cmd_len_i;
                        state_d = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (issue) begin
                    last_addr_d = addr_q;
                    addr_d      = (addr_q == addr_width_lp'(els_p - 1)) ? '0
                                                                       : addr_q + addr_width_lp'(1);
                    rem_d       = rem_q - len_width_lp'(1);
                    if (rem_q == len_width_lp'(1)) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (pop && last0_q) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Head is always entry 0; a returning read lands in the first free slot after any pop
        case ({infl_q, pop})
            2'b10: begin
                occ_d = occ_q + 2'd1;
                if (occ_q == 2'd0) begin
                    data0_d = mem_r_data_i;
                    last0_d = infl_last_q;
                end else begin
                    data1_d = mem_r_data_i;
                    last1_d = infl_last_q;
                end
            end
            2'b01: begin
                occ_d   = occ_q - 2'd1;
                data0_d = data1_q;
                last0_d = last1_q;
            end
            2'b11: begin
                if (occ_q == 2'd1) begin
                    data0_d = mem_r_data_i;
                    last0_d = infl_last_q;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = mem_r_data_i;
                    last1_d = infl_last_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            last_addr_q <= '0;
            rem_q       <= '0;
            occ_q       <= 2'd0;
            infl_q      <= 1'b0;
            infl_last_q <= 1'b0;
            done_q      <= 1'b0;
            last0_q     <= 1'b0;
            last1_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            last_addr_q <= last_addr_d;
            rem_q       <= rem_d;
            occ_q       <= occ_d;
            infl_q      <= infl_d;
            infl_last_q <= infl_last_d;
            done_q      <= done_d;
            last0_q     <= last0_d;
            last1_q     <= last1_d;
        end
    end

    always_ff @(posedge clk_i) begin
        data0_q <= data0_d;
        data1_q <= data1_d;
    end

endmodule

// File: tb/tb_qcl_bram_rd_stream.sv
// Bench for qcl_bram_rd_stream: BRAM model, command table, scoreboard of addresses and beats.
module tb_qcl_bram_rd_stream;

    localparam int W  = 16;
    localparam int N  = 10;
    localparam int AW = 4;
    localparam int LW = 4;

    logic          clk_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          cmd_v_i = 1'b0;
    logic [AW-1:0] cmd_addr_i = '0;
    logic [LW-1:0] cmd_len_i = '0;
    logic          cmd_ready_o;
    logic          mem_r_v_o;
    logic [AW-1:0] mem_r_addr_o;
    logic [W-1:0]  mem_r_data_i = '0;
    logic          data_v_o;
    logic [W-1:0]  data_o;
    logic          data_last_o;
    logic          data_ready_i = 1'b1;
    logic          done_o;

    qcl_bram_rd_stream #(.width_p(W), .els_p(N)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .cmd_v_i(cmd_v_i), .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i), .cmd_ready_o(cmd_ready_o),
        .mem_r_v_o(mem_r_v_o), .mem_r_addr_o(mem_r_addr_o), .mem_r_data_i(mem_r_data_i),
        .data_v_o(data_v_o), .data_o(data_o), .data_last_o(data_last_o),
        .data_ready_i(data_ready_i), .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int failures = 0;

    logic [W-1:0] mem [N];
    int           exp_addr_q[$];
    logic [W:0]   exp_data_q[$];
    int           issued = 0;
    int           popped = 0;
    int           max_out = 0;
    logic [W-1:0] last_word = '0;
    int           mon_ea;
    logic [W:0]   mon_ed;
    bit           bp_mode = 1'b0;
    logic         ready_force = 1'b1;

    typedef struct {
        int addr;
        int len;
        bit bp;
        int exp_first;
        int exp_done;
        int exp_last_word;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // BRAM model: registered read, garbage when not reading
    always @(posedge clk_i) begin
        if (mem_r_v_o) mem_r_data_i <= mem[mem_r_addr_o];
        else           mem_r_data_i <= 16'hDEAD;
    end

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            data_ready_i = bp_mode ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    always @(negedge clk_i) begin
        if (reset_i) begin
            exp_addr_q.delete();
            exp_data_q.delete();
            popped = issued;
        end else begin
            if (mem_r_v_o) begin
                if (exp_addr_q.size() == 0) chk("unexpected_issue", 1, 0);
                else begin
                    mon_ea = exp_addr_q.pop_front();
                    chk("rd_addr", int'(mem_r_addr_o), mon_ea);
                end
                issued++;
            end
            if (data_v_o && data_ready_i) begin
                if (exp_data_q.size() == 0) chk("unexpected_beat", 1, 0);
                else begin
                    mon_ed = exp_data_q.pop_front();
                    chk("beat_data", int'(data_o), int'(mon_ed[W-1:0]));
                    chk("beat_last", int'(data_last_o), int'(mon_ed[W]));
                end
                if (data_last_o) last_word = data_o;
                popped++;
            end
            if (issued - popped > max_out) max_out = issued - popped;
        end
    end

    function automatic void push_cmd(input int a, input int l);
        int ad;
        for (int i = 0; i < l; i++) begin
            ad = (a + i) % N;
            exp_addr_q.push_back(ad);
            exp_data_q.push_back({(i == l - 1), mem[ad]});
        end
    endfunction

    task automatic run_cmd(input int a, input int l, output int first, output int donec);
        bit acc;
        logic rdy;
        acc   = 1'b0;
        first = -1;
        donec = -1;
        @(posedge clk_i);
        #1;
        cmd_v_i    = 1'b1;
        cmd_addr_i = AW'(a);
        cmd_len_i  = LW'(l);
        push_cmd(a, l);
        for (int k = 0; k < 50; k++) begin
            @(negedge clk_i);
            rdy = cmd_ready_o;
            @(posedge clk_i);
            if (rdy) begin
                acc = 1'b1;
                break;
            end
        end
        #1;
        cmd_v_i = 1'b0;
        if (!acc) chk("cmd_accept_timeout", 0, 1);
        for (int k = 1; k <= 600; k++) begin
            @(negedge clk_i);
            if (data_v_o && first < 0) first = k;
            if (done_o) begin
                donec = k;
                break;
            end
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, donec, b0, b_iss, dones, lasts;
        bit acc_next, first_done;

        for (int i = 0; i < N; i++) mem[i] = W'(i + 'h100);

        vecs[0] = '{2, 4, 1'b0, 3, 7, 'h105};
        vecs[1] = '{8, 4, 1'b0, 3, 7, 'h101};
        vecs[2] = '{0, 0, 1'b0, -1, 1, 0};
        vecs[3] = '{1, 8, 1'b1, 0, 0, 'h108};
        vecs[4] = '{5, 12, 1'b0, 3, 15, 'h106};
        vecs[5] = '{9, 1, 1'b0, 3, 4, 'h109};
        vecs[6] = '{3, 10, 1'b1, 0, 0, 'h102};

        reset_i = 1'b1;
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_cmd_ready", int'(cmd_ready_o), 1);
        chk("rst_mem_r_v", int'(mem_r_v_o), 0);
        chk("rst_mem_r_addr", int'(mem_r_addr_o), 0);
        chk("rst_data_v", int'(data_v_o), 0);
        chk("rst_data_last", int'(data_last_o), 0);
        chk("rst_done", int'(done_o), 0);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;

        for (int i = 0; i < 7; i++) begin
            bp_mode = vecs[i].bp;
            b0 = popped;
            run_cmd(vecs[i].addr, vecs[i].len, first, donec);
            bp_mode = 1'b0;
            chk($sformatf("r%0d_done_seen", i), int'(donec > 0), 1);
            if (!vecs[i].bp) begin
                chk($sformatf("r%0d_first_lat", i), first, vecs[i].exp_first);
                chk($sformatf("r%0d_done_cycle", i), donec, vecs[i].exp_done);
            end
            chk($sformatf("r%0d_beats", i), popped - b0, vecs[i].len);
            if (vecs[i].len > 0)
                chk($sformatf("r%0d_last_word", i), int'(last_word), vecs[i].exp_last_word);
        end

        // Back-to-back commands presented continuously
        repeat (2) @(posedge clk_i);
        b0 = popped;
        dones = 0;
        lasts = 0;
        first_done = 1'b1;
        #1;
        cmd_v_i    = 1'b1;
        cmd_addr_i = AW'(0);
        cmd_len_i  = LW'(3);
        push_cmd(0, 3);
        @(negedge clk_i);
        acc_next = cmd_ready_o;
        @(posedge clk_i);
        chk("b2b_first_accept", int'(acc_next), 1);
        #1;
        cmd_addr_i = AW'(5);
        cmd_len_i  = LW'(2);
        push_cmd(5, 2);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (data_v_o && data_ready_i && data_last_o) lasts++;
            if (done_o) begin
                dones++;
                if (first_done) chk("b2b_ready_with_done", int'(cmd_ready_o), 1);
                first_done = 1'b0;
            end
            acc_next = cmd_v_i && cmd_ready_o;
            if (dones == 2) break;
            @(posedge clk_i);
            if (acc_next) begin
                #1;
                cmd_v_i = 1'b0;
            end
        end
        chk("b2b_dones", dones, 2);
        chk("b2b_lasts", lasts, 2);
        chk("b2b_beats", popped - b0, 5);

        // Reset in the middle of a stalled burst
        ready_force = 1'b0;
        repeat (2) @(posedge clk_i);
        b_iss = issued;
        #2;
        cmd_v_i    = 1'b1;
        cmd_addr_i = AW'(0);
        cmd_len_i  = LW'(6);
        push_cmd(0, 6);
        @(posedge clk_i);
        #1;
        cmd_v_i = 1'b0;
        repeat (6) @(negedge clk_i);
        chk("bp_stall_issues", issued - b_iss, 2);
        chk("bp_buffer_full_valid", int'(data_v_o), 1);
        #1;
        reset_i = 1'b1;
        #1;
        chk("midrst_data_v", int'(data_v_o), 0);
        chk("midrst_mem_r_v", int'(mem_r_v_o), 0);
        chk("midrst_cmd_ready", int'(cmd_ready_o), 1);
        chk("midrst_data_last", int'(data_last_o), 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        ready_force = 1'b1;
        @(posedge clk_i);
        b0 = popped;
        run_cmd(4, 2, first, donec);
        chk("post_rst_first_lat", first, 3);
        chk("post_rst_done_cycle", donec, 5);
        chk("post_rst_beats", popped - b0, 2);
        chk("post_rst_last_word", int'(last_word), 'h105);

        repeat (3) @(posedge clk_i);
        chk("max_outstanding_le2", int'(max_out <= 2), 1);
        chk("data_queue_empty", exp_data_q.size(), 0);
        chk("addr_queue_empty", exp_addr_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qcl_bram_rd_stream.md
# qcl_bram_rd_stream

Streaming read master for a single-clock simple-dual-port BRAM with 1-cycle read latency. It accepts a burst command (start address, word count) and drives the BRAM read port (`r_v`/`r_addr` in, `r_data` out one cycle later). It returns the words on a ready/valid output stream with a last-beat flag. A 2-entry skid buffer absorbs the read latency, so the stream sustains one word per cycle under full downstream readiness and never loses data under backpressure.

## Interface
- `width_p`, "inv": data word width; must equal the BRAM width.
- `els_p`, "inv": BRAM depth in words; any value ≥ 2, power of two not required.
- `addr_width_lp`, localparam `BSG_SAFE_CLOG2(els_p)`: address width.
- `len_width_lp`, localparam `BSG_SAFE_CLOG2(els_p+1)`: burst length width.
- `clk_i`  in  1  single clock, all logic on posedge.
- `reset_i`  in  1  asynchronous, active-high reset.
- `cmd_v_i`  in  1  command valid.
- `cmd_addr_i`  in  addr_width_lp  first word address; must be < els_p.
- `cmd_len_i`  in  len_width_lp  number of words to read; 0 allowed.
- `cmd_ready_o`  out  1  command accepted when `cmd_v_i & cmd_ready_o`.
- `mem_r_v_o`  out  1  BRAM read enable.
- `mem_r_addr_o`  out  addr_width_lp  BRAM read address.
- `mem_r_data_i`  in  width_p  BRAM read data, valid the cycle after `mem_r_v_o`.
- `data_v_o`  out  1  output word valid.
- `data_o`  out  width_p  output word.
- `data_last_o`  out  1  marks the final word of the burst; qualified by `data_v_o`.
- `data_ready_i`  in  1  downstream ready; beat transfers on `data_v_o & data_ready_i`.
- `done_o`  out  1  one-cycle pulse after the last beat transfers, or after a zero-length command is accepted.

## Operation
- States:
  - IDLE: `cmd_ready_o`=1. On accept with len>0, load addr and remaining-issue counter, go to ISSUE. On accept with len=0, pulse `done_o` next cycle and stay in IDLE.
  - ISSUE: issue reads while credit is available. After the final issue, go to DRAIN.
  - DRAIN: no issues. When the last beat transfers, pulse `done_o` and go to IDLE.
- Credit:
  - `occ` = buffer occupancy (0..2).
  - `infl` = 1 if a read was issued last cycle.
  - `pop` = `data_v_o & data_ready_i`.
  - Issue (`mem_r_v_o`=1) only if in ISSUE, remaining>0, and `occ + infl - pop < 2`.
  - The combinational path `data_ready_i` → `mem_r_v_o` is permitted.
- Data capture:
  - When `infl`=1, `mem_r_data_i` is written into the buffer at the next edge, unconditionally. Credit guarantees space.
  - Push and pop in the same cycle are allowed.
- Buffer ordering: FIFO order. `data_o` comes from the buffer head register, not combinationally from `mem_r_data_i`.
- Address: increments per issue. It wraps from els_p-1 to 0 by compare, not modulo-2^n. Bursts with len > els_p reread wrapped addresses.
- Last flag: tagged at issue time when remaining==1 and carried through the buffer alongside the data.
- `mem_r_addr_o` holds its last value when `mem_r_v_o`=0. `data_o` is don't-care when `data_v_o`=0.
- Reset:
  - Asynchronous. Returns to IDLE, clears `occ`, `infl`, counters and `done_o`.
  - In-flight BRAM data is discarded.
  - Takes effect mid-burst with no further `mem_r_v_o` assertion.

## Timing
- Reset values:
  - `cmd_ready_o`=1.
  - `mem_r_v_o`=0, `mem_r_addr_o`=0.
  - `data_v_o`=0, `data_last_o`=0.
  - `done_o`=0.
- Latency:
  - Command accepted at edge E0.
  - First `mem_r_v_o` in the cycle after E0.
  - First `data_v_o` two cycles after that, i.e. 3 cycles after the accept edge.
- Throughput: 1 word/cycle with `data_ready_i` held high.
- Burst duration: a len=N burst with no backpressure shows `data_v_o` on N consecutive cycles.
- Completion:
  - `done_o` pulses in the cycle after the last-beat handshake.
  - `cmd_ready_o` returns to 1 in that same cycle, so back-to-back bursts have a 1-cycle gap in the command path.
- Backpressure bound: with `data_ready_i` low, at most 2 words are buffered and issuing stalls. There is no duplicated or dropped word.

## Test plan
- Basic burst: els_p=16, BRAM[i]=i+0x100, cmd addr=2 len=4, ready=1 → `mem_r_addr_o` 2,3,4,5 on consecutive cycles; `data_o` 0x102..0x105 starting 3 cycles after accept; last on 0x105; `done_o` 1 cycle later.
- Backpressure: len=8, `data_ready_i` random 50% → exact in-order sequence of 8 words; `occ` never exceeds 2; no issue while credit is exhausted.
- Wrap: els_p=10, addr=8 len=4 → reads 8,9,0,1; last on word from addr 1.
- Zero length: cmd len=0 → no `mem_r_v_o`, no `data_v_o`, `done_o` pulses the cycle after accept.
- Reset mid-burst: len=6 with ready=0 after 2 issues; assert `reset_i` → `data_v_o`, `mem_r_v_o` drop immediately; after release, a new len=2 burst returns only its own 2 words.
- Back-to-back: two commands (addr 0 len 3, addr 5 len 2) presented continuously → 5 correct words; last asserted twice; two `done_o` pulses.
